// File: rtl/gpr_writeback_pkg.sv
// rtl/gpr_writeback_pkg.sv - shared constants and queued-entry field layout for gpr_writeback
package gpr_writeback_pkg;

    // Architectural register numbers with special handling.
    localparam int REG_ZERO     = 0;
    localparam int OVERFLOW_REG = 30;

    // A queued entry is packed MSB to LSB as {valid, addr, data, of_en, overflow}.
    // The widths are parameters of the user, so the layout is given as bit offsets.
    localparam int OVF_BIT  = 0;
    localparam int OFEN_BIT = 1;
    localparam int DATA_LSB = 2;

    function automatic int entry_w(input int addr_w, input int data_w);
        return data_w + addr_w + 3;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return DATA_LSB + data_w;
    endfunction

    function automatic int valid_bit(input int addr_w, input int data_w);
        return DATA_LSB + data_w + addr_w;
    endfunction

endpackage

// File: rtl/gpr_writeback_wb_fifo.sv
// rtl/gpr_writeback_wb_fifo.sv - DEPTH-entry sync FIFO exposing every slot for associative search
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   head_ptr,
    output logic [W-1:0]               head_data,
    output logic [W-1:0]               entries [DEPTH],
    output logic [DEPTH-1:0]           live
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    // Guard against overrun/underrun so a misbehaving caller cannot corrupt the count.
    assign do_push = push && (count < CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop)  head <= head + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; stale slots are masked by live.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[tail] <= din;
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = CW'(PW'(i) - head) < count;
        end
    end

    assign head_ptr  = head;
    assign head_data = mem[head];
    assign entries   = mem;

endmodule

// File: rtl/gpr_writeback.sv
// rtl/gpr_writeback.sv - register-file write queue with decode forwarding (optional WB_FWD_EN)
module gpr_writeback
    import gpr_writeback_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_of_en,
    input  logic                      in_overflow,
    input  logic                      wb_hold,
    output logic                      write_en,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic                      of_write_en,
    output logic                      overflow,
    input  logic [ADDR_W-1:0]         fwd_addr_1,
    input  logic [ADDR_W-1:0]         fwd_addr_2,
    output logic                      fwd_hit_1,
    output logic                      fwd_hit_2,
    output logic [DATA_W-1:0]         fwd_data_1,
    output logic [DATA_W-1:0]         fwd_data_2,
    output logic                      of_pending,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int EW     = entry_w(ADDR_W, DATA_W);
    localparam int A_LSB  = addr_lsb(DATA_W);
    localparam int V_BIT  = valid_bit(ADDR_W, DATA_W);

    logic            push;
    logic            pop;
    logic            trap;
    logic [EW-1:0]   din;
    logic [EW-1:0]   head_data;
    logic [EW-1:0]   entries [DEPTH];
    logic [PW-1:0]   head_ptr;
    logic [DEPTH-1:0] live;

    // Writes to $0 are dropped at the door unless they carry an overflow trap.
    assign trap     = in_of_en && in_overflow;
    assign in_ready = count < CW'(DEPTH);
    assign push     = in_valid && in_ready && !((in_addr == ADDR_W'(REG_ZERO)) && !trap);
    // Reset blocks the drain so a queued write cannot commit in the reset cycle.
    assign pop      = !rst && (count != '0) && !wb_hold;
    assign din      = {1'b1, in_addr, in_data, in_of_en, in_overflow};

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .din       (din),
        .pop       (pop),
        .count     (count),
        .head_ptr  (head_ptr),
        .head_data (head_data),
        .entries   (entries),
        .live      (live)
    );

    // Register-file write port driven straight from the head entry while draining.
    always_comb begin
        write_en    = 1'b0;
        write_addr  = '0;
        write_data  = '0;
        of_write_en = 1'b0;
        overflow    = 1'b0;
        if (pop) begin
            write_en    = 1'b1;
            write_addr  = head_data[A_LSB +: ADDR_W];
            write_data  = head_data[DATA_LSB +: DATA_W];
            of_write_en = head_data[OFEN_BIT];
            overflow    = head_data[OVF_BIT];
        end
    end

    // Any queued trapping entry makes decode hold off reads of the overflow register.
    always_comb begin
        of_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && entries[i][OFEN_BIT] && entries[i][OVF_BIT]) of_pending = 1'b1;
        end
    end

`ifdef WB_FWD_EN
    function automatic logic fwd_match(input logic [EW-1:0] e, input logic [ADDR_W-1:0] a);
        return e[V_BIT] && (a != ADDR_W'(REG_ZERO)) && (e[A_LSB +: ADDR_W] == a)
               && !(e[OFEN_BIT] && e[OVF_BIT]);
    endfunction

    // Walk oldest to newest so the youngest matching entry overrides earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit_1  = 1'b0;
        fwd_hit_2  = 1'b0;
        fwd_data_1 = '0;
        fwd_data_2 = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (CW'(k) < count) begin
                if (fwd_match(entries[idx], fwd_addr_1)) begin
                    fwd_hit_1  = 1'b1;
                    fwd_data_1 = entries[idx][DATA_LSB +: DATA_W];
                end
                if (fwd_match(entries[idx], fwd_addr_2)) begin
                    fwd_hit_2  = 1'b1;
                    fwd_data_2 = entries[idx][DATA_LSB +: DATA_W];
                end
            end
        end
    end
`else
    // Without forwarding decode stalls on a non-empty queue instead.
    assign fwd_hit_1  = 1'b0;
    assign fwd_hit_2  = 1'b0;
    assign fwd_data_1 = '0;
    assign fwd_data_2 = '0;

    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr_1, fwd_addr_2, head_ptr};
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
// tb/tb_gpr_writeback.sv - directed self-checking bench for gpr_writeback
module tb_gpr_writeback;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        in_of_en;
    logic        in_overflow;
    logic        wb_hold;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        of_write_en;
    logic        overflow;
    logic [4:0]  fwd_addr_1;
    logic [4:0]  fwd_addr_2;
    logic        fwd_hit_1;
    logic        fwd_hit_2;
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;
    logic        of_pending;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    gpr_writeback #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_of_en    (in_of_en),
        .in_overflow (in_overflow),
        .wb_hold     (wb_hold),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .of_write_en (of_write_en),
        .overflow    (overflow),
        .fwd_addr_1  (fwd_addr_1),
        .fwd_addr_2  (fwd_addr_2),
        .fwd_hit_1   (fwd_hit_1),
        .fwd_hit_2   (fwd_hit_2),
        .fwd_data_1  (fwd_data_1),
        .fwd_data_2  (fwd_data_2),
        .of_pending  (of_pending),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push_one(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en got %b want 0", write_en); end
        n_checks++; if (of_pending !== 1'b0) begin n_fail++; $display("FAIL reset_of_pending got %b want 0", of_pending); end
        n_checks++; if (fwd_hit_1 !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_hit got %b want 0", fwd_hit_1); end
    endtask

    task automatic test_single();
        push_one(5'd5, 32'hDEADBEEF);
        settle();
        n_checks++; if (write_en !== 1'b1) begin n_fail++; $display("FAIL single_write_en got %b want 1", write_en); end
        n_checks++; if (write_addr !== 5'd5) begin n_fail++; $display("FAIL single_addr got %0d want 5", write_addr); end
        n_checks++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data got %h want deadbeef", write_data); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
        tick();
        settle();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_drained got %0d want 0", count); end
        n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL single_idle_we got %b want 0", write_en); end
    endtask

    task automatic test_hold_full();
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push_one(5'(i), 32'h100 + 32'(i));
        settle();
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL hold_write_en got %b want 0", write_en); end
        push_one(5'd9, 32'h999);
        settle();
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fifth_push_count got %0d want 4", count); end
        wb_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            settle();
            n_checks++; if (write_en !== 1'b1 || write_addr !== 5'(i) || write_data !== 32'h100 + 32'(i)) begin
                n_fail++; $display("FAIL drain_order_%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h", i, write_en, write_addr, write_data, i, 32'h100 + 32'(i));
            end
            tick();
        end
        settle();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_empty got %0d want 0", count); end
    endtask

    task automatic test_forward();
        wb_hold    = 1'b1;
        fwd_addr_1 = 5'd7;
        fwd_addr_2 = 5'd3;
        push_one(5'd7, 32'h11);
        push_one(5'd7, 32'h22);
        settle();
        n_checks++; if (fwd_hit_1 !== FWD) begin n_fail++; $display("FAIL fwd_hit_newest got %b want %b", fwd_hit_1, FWD); end
        n_checks++; if (fwd_data_1 !== (FWD ? 32'h22 : 32'h0)) begin n_fail++; $display("FAIL fwd_data_newest got %h want %h", fwd_data_1, FWD ? 32'h22 : 32'h0); end
        n_checks++; if (fwd_hit_2 !== 1'b0) begin n_fail++; $display("FAIL fwd_miss got %b want 0", fwd_hit_2); end
        fwd_addr_2 = 5'd0;
        settle();
        n_checks++; if (fwd_hit_2 !== 1'b0) begin n_fail++; $display("FAIL fwd_zero_addr got %b want 0", fwd_hit_2); end
        wb_hold = 1'b0;
        settle();
        n_checks++; if (write_data !== 32'h11 || write_addr !== 5'd7) begin n_fail++; $display("FAIL fwd_drain_first got a=%0d d=%h want a=7 d=11", write_addr, write_data); end
        n_checks++; if (fwd_data_1 !== (FWD ? 32'h22 : 32'h0)) begin n_fail++; $display("FAIL fwd_during_pop got %h want %h", fwd_data_1, FWD ? 32'h22 : 32'h0); end
        tick();
        settle();
        n_checks++; if (write_data !== 32'h22) begin n_fail++; $display("FAIL fwd_drain_second got %h want 22", write_data); end
        n_checks++; if (fwd_hit_1 !== FWD) begin n_fail++; $display("FAIL fwd_popping_entry got %b want %b", fwd_hit_1, FWD); end
        tick();
        settle();
        n_checks++; if (fwd_hit_1 !== 1'b0) begin n_fail++; $display("FAIL fwd_after_drain got %b want 0", fwd_hit_1); end
    endtask

    task automatic test_zero_overflow();
        push_one(5'd0, 32'h55);
        settle();
        n_checks++; if (count !== 3'd0 || write_en !== 1'b0) begin n_fail++; $display("FAIL zero_dropped got count=%0d we=%b want 0 0", count, write_en); end
        wb_hold     = 1'b1;
        in_of_en    = 1'b1;
        in_overflow = 1'b1;
        fwd_addr_1  = 5'd8;
        push_one(5'd8, 32'h77);
        in_of_en    = 1'b0;
        in_overflow = 1'b0;
        settle();
        n_checks++; if (of_pending !== 1'b1) begin n_fail++; $display("FAIL of_pending_set got %b want 1", of_pending); end
        n_checks++; if (fwd_hit_1 !== 1'b0) begin n_fail++; $display("FAIL ovf_no_fwd got %b want 0", fwd_hit_1); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL ovf_count got %0d want 1", count); end
        wb_hold = 1'b0;
        settle();
        n_checks++; if (write_en !== 1'b1 || write_addr !== 5'd8 || of_write_en !== 1'b1 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drain got we=%b a=%0d ofe=%b ovf=%b want 1 8 1 1", write_en, write_addr, of_write_en, overflow);
        end
        tick();
        settle();
        n_checks++; if (of_pending !== 1'b0) begin n_fail++; $display("FAIL of_pending_clear got %b want 0", of_pending); end
    endtask

    task automatic test_full_simul();
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) push_one(5'(10 + i), 32'hC0 + 32'(i));
        wb_hold  = 1'b0;
        in_valid = 1'b1;
        in_addr  = 5'd14;
        in_data  = 32'hC4;
        tick();
        settle();
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_no_push got %0d want 3", count); end
        tick();
        in_valid = 1'b0;
        settle();
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL simul_push_pop got %0d want 3", count); end
        for (int i = 2; i <= 4; i++) begin
            n_checks++; if (write_addr !== 5'(10 + i) || write_data !== 32'hC0 + 32'(i)) begin
                n_fail++; $display("FAIL simul_order_%0d got a=%0d d=%h want a=%0d d=%h", i, write_addr, write_data, 10 + i, 32'hC0 + 32'(i));
            end
            tick();
            settle();
        end
        n_checks++; if (count !== 3'd0 || write_en !== 1'b0) begin n_fail++; $display("FAIL simul_empty got count=%0d we=%b want 0 0", count, write_en); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_addr  = 5'(16 + i);
            in_data  = 32'hA0 + 32'(i);
            settle();
            if (i > 0) begin
                n_checks++; if (write_en !== 1'b1 || write_addr !== 5'(15 + i) || write_data !== 32'h9F + 32'(i)) begin
                    n_fail++; $display("FAIL wrap_%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h", i, write_en, write_addr, write_data, 15 + i, 32'h9F + 32'(i));
                end
            end
            tick();
        end
        in_valid = 1'b0;
        settle();
        n_checks++; if (write_addr !== 5'd24 || write_data !== 32'hA8) begin n_fail++; $display("FAIL wrap_last got a=%0d d=%h want a=24 d=a8", write_addr, write_data); end
        tick();
        settle();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_empty got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        wb_hold    = 1'b1;
        fwd_addr_1 = 5'd20;
        for (int i = 0; i < 3; i++) push_one(5'(20 + i), 32'hE0 + 32'(i));
        settle();
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_queued got %0d want 3", count); end
        rst     = 1'b1;
        wb_hold = 1'b0;
        settle();
        n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_write_en got %b want 0", write_en); end
        tick();
        rst = 1'b0;
        settle();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
        n_checks++; if (fwd_hit_1 !== 1'b0 || fwd_hit_2 !== 1'b0) begin n_fail++; $display("FAIL mid_fwd got %b%b want 00", fwd_hit_1, fwd_hit_2); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL mid_no_commit_%0d got %b want 0", i, write_en); end
            tick();
            settle();
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_addr     = '0;
        in_data     = '0;
        in_of_en    = 1'b0;
        in_overflow = 1'b0;
        wb_hold     = 1'b0;
        fwd_addr_1  = '0;
        fwd_addr_2  = '0;
        test_reset();
        test_single();
        test_hold_full();
        test_forward();
        test_zero_overflow();
        test_full_simul();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
